// File: rtl/echo_delay_ctrl.sv
// Per-sample echo controller: reads the delayed sample from the smart_ram buffer, mixes it with
// the input at a programmable wet gain, writes the result back and emits the processed sample.
module echo_delay_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int FEEDBACK   = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_sample_in,
  input  logic                  i_sample_valid,
  input  logic                  i_enable,
  input  logic [7:0]            i_gain,
  input  logic [ADDR_WIDTH-3:0] i_delay,
  output logic [DATA_WIDTH-1:0] o_sample_out,
  output logic                  o_sample_out_valid,
  output logic                  o_overrun,
  output logic                  o_ram_err,
  output logic [DATA_WIDTH-1:0] o_ram_data_in,
  output logic [ADDR_WIDTH-1:0] o_ram_offset,
  output logic                  o_ram_wr,
  output logic                  o_ram_rd,
  input  logic [DATA_WIDTH-1:0] i_ram_data_out,
  input  logic                  i_ram_write_finish,
  input  logic                  i_ram_read_finish,
  input  logic                  i_ram_available
);

  // state     | meaning
  // S_IDLE    | waiting for a sample strobe
  // S_RD_REQ  | waiting for the RAM to go idle, then issue the delayed-sample read
  // S_RD_WAIT | waiting for read_finish (or timeout)
  // S_MIX     | compute wet mix and saturate
  // S_WR_REQ  | waiting for the RAM to go idle, then issue the buffer write
  // S_WR_WAIT | waiting for write_finish (or timeout)
  // S_OUT     | present the processed sample
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_MIX, S_WR_REQ, S_WR_WAIT, S_OUT
  } state_t;

  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                  r_state;
  logic signed [DW-1:0]    r_x;
  logic signed [DW-1:0]    r_dl;
  logic [ADDR_WIDTH-3:0]   r_d;
  logic [7:0]              r_g;
  logic                    r_en;
  logic [DW-1:0]           r_y;
  logic [CNT_W-1:0]        r_tmo;
  logic [DW-1:0]           r_sample_out;
  logic                    r_sample_out_valid;
  logic                    r_overrun;
  logic                    r_ram_err;
  logic [DW-1:0]           r_ram_data_in;
  logic [ADDR_WIDTH-1:0]   r_ram_offset;
  logic                    r_ram_wr;
  logic                    r_ram_rd;

  logic signed [DW+8:0]    w_prod;
  logic signed [DW+8:0]    w_wet_full;
  logic signed [DW-1:0]    w_wet;
  logic signed [DW:0]      w_sum;
  logic [DW-1:0]           w_sat;
  logic [DW-1:0]           w_y;
  logic                    w_tmo_hit;

  // Signed delayed sample times unsigned Q0.8 gain; the shift floors toward -inf.
  assign w_prod     = $signed(r_dl) * $signed({1'b0, r_g});
  assign w_wet_full = w_prod >>> 8;
  assign w_wet      = w_wet_full[DW-1:0];
  assign w_sum      = $signed({r_x[DW-1], r_x}) + $signed({w_wet[DW-1], w_wet});

  always_comb begin
    w_sat = w_sum[DW-1:0];
    if (w_sum[DW] != w_sum[DW-1])
      w_sat = w_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  assign w_y       = r_en ? w_sat : r_x;
  assign w_tmo_hit = (r_tmo >= CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state            <= S_IDLE;
      r_x                <= '0;
      r_dl               <= '0;
      r_d                <= '0;
      r_g                <= '0;
      r_en               <= 1'b0;
      r_y                <= '0;
      r_tmo              <= '0;
      r_sample_out       <= '0;
      r_sample_out_valid <= 1'b0;
      r_overrun          <= 1'b0;
      r_ram_err          <= 1'b0;
      r_ram_data_in      <= '0;
      r_ram_offset       <= '0;
      r_ram_wr           <= 1'b0;
      r_ram_rd           <= 1'b0;
    end else begin
      r_sample_out_valid <= 1'b0;
      r_ram_rd           <= 1'b0;
      r_ram_wr           <= 1'b0;
      if (i_sample_valid && (r_state != S_IDLE))
        r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_sample_valid) begin
            r_x   <= i_sample_in;
            r_d   <= i_delay;
            r_g   <= i_gain;
            r_en  <= i_enable;
            r_tmo <= '0;
            if (i_delay != '0) begin
              r_state <= S_RD_REQ;
            end else begin
              r_dl    <= '0;
              r_state <= S_MIX;
            end
          end
        end
        S_RD_REQ: begin
          if (w_tmo_hit) begin
            r_ram_err <= 1'b1;
            r_dl      <= '0;
            r_state   <= S_MIX;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (i_ram_available) begin
              r_ram_rd     <= 1'b1;
              r_ram_offset <= {r_d, 2'b00};
              r_state      <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (i_ram_read_finish) begin
            r_dl    <= i_ram_data_out;
            r_state <= S_MIX;
          end else if (w_tmo_hit) begin
            r_ram_err <= 1'b1;
            r_dl      <= '0;
            r_state   <= S_MIX;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_MIX: begin
          r_y     <= w_y;
          r_tmo   <= '0;
          r_state <= S_WR_REQ;
        end
        S_WR_REQ: begin
          if (w_tmo_hit) begin
            r_ram_err <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (i_ram_available) begin
              r_ram_wr      <= 1'b1;
              r_ram_offset  <= '0;
              r_ram_data_in <= (FEEDBACK != 0) ? r_y : r_x;
              r_state       <= S_WR_WAIT;
            end
          end
        end
        S_WR_WAIT: begin
          if (i_ram_write_finish) begin
            r_state <= S_OUT;
          end else if (w_tmo_hit) begin
            r_ram_err <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_OUT: begin
          r_sample_out       <= r_y;
          r_sample_out_valid <= 1'b1;
          r_state            <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_sample_out       = r_sample_out;
  assign o_sample_out_valid = r_sample_out_valid;
  assign o_overrun          = r_overrun;
  assign o_ram_err          = r_ram_err;
  assign o_ram_data_in      = r_ram_data_in;
  assign o_ram_offset       = r_ram_offset;
  assign o_ram_wr           = r_ram_wr;
  assign o_ram_rd           = r_ram_rd;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Directed bench for echo_delay_ctrl: a feedback and a non-feedback instance share one RAM model
// that answers each request four cycles after it is issued.
module tb_echo_delay_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               enable;
  logic [7:0]         gain;
  logic [10:0]        delay;
  logic signed [15:0] ram_data_out;
  logic               ram_write_finish;
  logic               ram_read_finish;
  logic               ram_available;

  logic [15:0] sample_out, nf_sample_out;
  logic        sample_out_valid, nf_sample_out_valid;
  logic        overrun, nf_overrun;
  logic        ram_err, nf_ram_err;
  logic [15:0] ram_data_in, nf_ram_data_in;
  logic [12:0] ram_offset, nf_ram_offset;
  logic        ram_wr, nf_ram_wr;
  logic        ram_rd, nf_ram_rd;

  int n_assert = 0;
  int n_fail   = 0;
  int n_rd = 0, n_wr = 0;
  logic [12:0] rd_off, wr_off;
  logic [15:0] wr_data, nf_wr_data;
  logic signed [15:0] rd_data;
  bit  stuck_rd = 1'b0;
  int  rd_cnt = 0, wr_cnt = 0;
  int  lat;

  always #5 clk = ~clk;

  echo_delay_ctrl #(.FEEDBACK(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_sample_in(sample_in), .i_sample_valid(sample_valid),
    .i_enable(enable), .i_gain(gain), .i_delay(delay),
    .o_sample_out(sample_out), .o_sample_out_valid(sample_out_valid),
    .o_overrun(overrun), .o_ram_err(ram_err), .o_ram_data_in(ram_data_in),
    .o_ram_offset(ram_offset), .o_ram_wr(ram_wr), .o_ram_rd(ram_rd),
    .i_ram_data_out(ram_data_out), .i_ram_write_finish(ram_write_finish),
    .i_ram_read_finish(ram_read_finish), .i_ram_available(ram_available)
  );

  echo_delay_ctrl #(.FEEDBACK(0)) u_dut_nf (
    .i_clk(clk), .i_rst(rst), .i_sample_in(sample_in), .i_sample_valid(sample_valid),
    .i_enable(enable), .i_gain(gain), .i_delay(delay),
    .o_sample_out(nf_sample_out), .o_sample_out_valid(nf_sample_out_valid),
    .o_overrun(nf_overrun), .o_ram_err(nf_ram_err), .o_ram_data_in(nf_ram_data_in),
    .o_ram_offset(nf_ram_offset), .o_ram_wr(nf_ram_wr), .o_ram_rd(nf_ram_rd),
    .i_ram_data_out(ram_data_out), .i_ram_write_finish(ram_write_finish),
    .i_ram_read_finish(ram_read_finish), .i_ram_available(ram_available)
  );

  // RAM model: finish is sampled by the DUT on the 4th rising edge after the request cycle.
  always @(negedge clk) begin
    ram_read_finish  = 1'b0;
    ram_write_finish = 1'b0;
    if (rd_cnt != 0) begin
      if (rd_cnt == 1) begin
        ram_read_finish = 1'b1;
        ram_data_out    = rd_data;
      end
      rd_cnt--;
    end else if (ram_rd && !stuck_rd) begin
      rd_cnt = 3;
    end
    if (wr_cnt != 0) begin
      if (wr_cnt == 1) ram_write_finish = 1'b1;
      wr_cnt--;
    end else if (ram_wr) begin
      wr_cnt = 3;
    end
    if (ram_rd) begin n_rd++; rd_off = ram_offset; end
    if (ram_wr) begin n_wr++; wr_off = ram_offset; wr_data = ram_data_in; end
    if (nf_ram_wr) nf_wr_data = nf_ram_data_in;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input int x, input int d, input int g, input bit en);
    @(negedge clk);
    sample_in    = 16'(x);
    delay        = 11'(d);
    gain         = 8'(g);
    enable       = en;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // lat counts cycles from the strobe cycle to the sample_out_valid cycle.
  task automatic wait_out(input string tag, output int l);
    l = 1;
    while (!sample_out_valid && l < 300) begin
      @(negedge clk);
      l++;
    end
    chk({tag, "_valid_seen"}, 32'(sample_out_valid), 1);
  endtask

  task automatic run(input string tag, input int x, input int d, input int g, input bit en,
                     output int l);
    strobe(x, d, g, en);
    wait_out(tag, l);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample_in = '0; sample_valid = 1'b0; enable = 1'b0; gain = '0; delay = '0;
    ram_data_out = '0; ram_write_finish = 1'b0; ram_read_finish = 1'b0; ram_available = 1'b1;
    rd_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_out",     32'(sample_out), 0);
    chk("rst_valid",   32'(sample_out_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_err",     32'(ram_err), 0);
    chk("rst_rdwr",    32'({ram_rd, ram_wr}), 0);
    chk("rst_offset",  32'(ram_offset), 0);

    // Basic echo: 1000 + (2000*128)>>8 = 2000
    n_rd = 0; n_wr = 0; rd_data = 16'sd2000;
    run("basic", 1000, 4, 128, 1'b1, lat);
    chk("basic_out",    $signed(sample_out), 2000);
    chk("basic_lat",    lat, 13);
    chk("basic_nrd",    n_rd, 1);
    chk("basic_rdoff",  32'(rd_off), 16);
    chk("basic_nwr",    n_wr, 1);
    chk("basic_wroff",  32'(wr_off), 0);
    chk("basic_wrdata", $signed(wr_data), 2000);
    chk("nofb_wrdata",  $signed(nf_wr_data), 1000);

    // Saturation: 30000 + 29882 -> 32767; -30000 + (-29883) -> -32768
    rd_data = 16'sd30000;
    run("satp", 30000, 1, 255, 1'b1, lat);
    chk("satp_out",     $signed(sample_out), 32767);
    chk("satp_fb_wr",   $signed(wr_data), 32767);
    chk("satp_nofb_wr", $signed(nf_wr_data), 30000);
    chk("satp_nofb_out", $signed(nf_sample_out), 32767);
    rd_data = -16'sd30000;
    run("satn", -30000, 1, 255, 1'b1, lat);
    chk("satn_out",     $signed(sample_out), -32768);
    chk("satn_nofb_wr", $signed(nf_wr_data), -30000);

    // Reset held 3 cycles while waiting on the read
    strobe(111, 9, 100, 1'b1);
    @(negedge clk);
    chk("midrst_rd_issued", 32'(ram_rd), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rdwr", 32'({ram_rd, ram_wr}), 0);
    chk("midrst_out",  32'(sample_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_offset", 32'(ram_offset), 0);
    chk("midrst_data",   32'(ram_data_in), 0);
    repeat (3) @(negedge clk);

    // Overrun: second strobe 5 cycles after the first is dropped; 500 + (100*64)>>8 = 525
    n_rd = 0; n_wr = 0; rd_data = 16'sd100;
    strobe(500, 2, 64, 1'b1);
    repeat (4) @(negedge clk);
    sample_in = 16'sd9999; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_out("ovr", lat);
    chk("ovr_out",  $signed(sample_out), 525);
    chk("ovr_flag", 32'(overrun), 1);
    repeat (20) @(negedge clk);
    chk("ovr_nrd",  n_rd, 1);
    chk("ovr_nwr",  n_wr, 1);
    chk("ovr_err",  32'(ram_err), 0);

    do_reset(2);
    chk("ovr_cleared", 32'(overrun), 0);

    // Read never finishes: 64-cycle timeout, dry output, FSM returns to IDLE
    stuck_rd = 1'b1; n_wr = 0; rd_data = 16'sd5000;
    run("tmo", -1234, 7, 200, 1'b1, lat);
    chk("tmo_out", $signed(sample_out), -1234);
    chk("tmo_lat", lat, 72);
    chk("tmo_err", 32'(ram_err), 1);
    chk("tmo_nwr", n_wr, 1);
    stuck_rd = 1'b0;
    run("tmo_next", 77, 0, 255, 1'b1, lat);
    chk("tmo_next_out", $signed(sample_out), 77);
    chk("tmo_next_lat", lat, 8);
    chk("tmo_err_sticky", 32'(ram_err), 1);

    do_reset(2);

    // RAM busy for 20 cycles: read waits, then one pulse; 300 + (400*128)>>8 = 500
    n_rd = 0; rd_data = 16'sd400; ram_available = 1'b0;
    strobe(300, 5, 128, 1'b1);
    repeat (20) @(negedge clk);
    chk("busy_nrd_wait", n_rd, 0);
    chk("busy_rd_low",   32'(ram_rd), 0);
    ram_available = 1'b1;
    wait_out("busy", lat);
    chk("busy_out", $signed(sample_out), 500);
    chk("busy_nrd", n_rd, 1);
    chk("busy_err", 32'(ram_err), 0);

    // delay=0 issues no read; enable=0 and gain=0 give the dry sample
    n_rd = 0;
    run("d0", -321, 0, 200, 1'b1, lat);
    chk("d0_out", $signed(sample_out), -321);
    chk("d0_nrd", n_rd, 0);
    run("en0", -50, 3, 255, 1'b0, lat);
    chk("en0_out", $signed(sample_out), -50);
    run("g0", 123, 3, 0, 1'b1, lat);
    chk("g0_out", $signed(sample_out), 123);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
